usb3_in_sched: RTL and testbench
================================

Name: usb3_in_sched

Overview:
- Parametrised IN (device-to-host) transaction scheduler for the USB 3.0 protocol layer.
- Serves NUM_EP bulk IN endpoints, numbered 1..NUM_EP.
- Sits between link-layer TP/DPH interfaces and per-endpoint buffers; adds per-endpoint NRDY/ERDY tracking, multi-packet bursts, short-packet EOB, and DPP timeout/abort.

Parameters:
- NUM_EP, 4, number of IN endpoints (1..15).
- MAX_BURST, 4, max DPPs per host ACK (1..16).
- MAX_PKT, 1024, full packet size in bytes; shorter length marks end of burst.
- DPP_TIMEOUT, 1024, local_clk cycles allowed between tx_dpp_ack and tx_dpp_done.

Ports:
- local_clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- link_u0  in  1  LTSSM is in U0
- rx_ack  in  1  one-cycle pulse: ACK TP received with PP set
- rx_ack_endp  in  4  endpoint number of ACK
- rx_ack_nump  in  5  packets requested
- rx_ack_seq  in  5  sequence number host expects
- ep_hasdata  in  NUM_EP  bit i: endpoint i+1 buffer committed
- ep_len  in  NUM_EP*11  bytes in buffer, slice [11i+10:11i] = endpoint i+1
- ep_arm  out  NUM_EP  one-cycle pulse: release buffer of endpoint i+1
- ep_sel  out  4  endpoint driving buffer read mux; 0 when idle
- tx_tp  out  1  TP request, held until tx_tp_ack
- tx_tp_subtype  out  4  NRDY or ERDY codes from the shared constants
- tx_tp_endp  out  4  TP endpoint
- tx_tp_nump  out  5  0 for NRDY, 1 for ERDY
- tx_tp_ack  in  1  link accepted TP
- tx_dph  out  1  DPH request, held until tx_dpp_ack
- tx_dph_endp  out  4  DPH endpoint
- tx_dph_seq  out  5  DPH sequence
- tx_dph_len  out  16  DPH length, zero-extended ep_len
- tx_dph_eob  out  1  last packet of burst
- tx_dpp_ack  in  1  link started DPP
- tx_dpp_done  in  1  link finished DPP
- err_miss_ack  out  1  sticky: ACK arrived while busy
- err_bad_endp  out  1  sticky: ACK to endpoint 0 or > NUM_EP
- err_dpp_timeout  out  1  sticky: DPP done not seen, or link left U0, mid-DPP

Behaviour:
- Reset (synchronous, reset_n low at a local_clk edge):
  - All outputs 0.
  - State IDLE; pend[NUM_EP-1:0] = 0; burst counter = 0; sequence = 0.
  - Reset mid-operation aborts immediately with no ep_arm pulse.
- Registered state machine: IDLE, NRDY, ERDY, DPH, DPP, ARM, SETTLE.
- IDLE, rx_ack with nump = 0: ignored.
- IDLE, rx_ack with nump > 0:
  - endp = 0 or endp > NUM_EP: set err_bad_endp, stay IDLE.
  - Otherwise latch e = endp, seq = rx_ack_seq, burst = min(nump, MAX_BURST); set ep_sel = e.
  - If ep_hasdata[e-1]: go DPH next cycle. Else go NRDY.
- IDLE, no rx_ack, and any pend bit whose ep_hasdata is set:
  - Lowest-numbered such endpoint wins; set ep_sel, go ERDY.
  - rx_ack in the same cycle takes priority over ERDY.
- NRDY: assert tx_tp (subtype NRDY, endp e, nump 0). On tx_tp_ack set pend[e-1], go IDLE.
- ERDY: assert tx_tp (subtype ERDY, nump 1). On tx_tp_ack clear pend[e-1], go IDLE; the host re-issues ACK.
- DPH:
  - Assert tx_dph with endp e, seq, len = ep_len slice.
  - eob = (burst == 1) or (len < MAX_PKT).
  - On tx_dpp_ack: clear timeout counter, go DPP.
- DPP, completion: on tx_dpp_done go ARM.
- DPP, abort: if the counter reaches DPP_TIMEOUT, or link_u0 drops:
  - set err_dpp_timeout, go IDLE, no arm (buffer kept for host retry);
  - ep_sel = 0.
- ARM:
  - Pulse ep_arm[e-1] for exactly one cycle.
  - seq = seq+1 mod 32 (31 wraps to 0); burst = burst-1.
  - If the packet was eob, or burst now 0: go IDLE, ep_sel = 0. Else go SETTLE.
- SETTLE: one cycle for buffer status to update.
  - ep_hasdata[e-1] set: go DPH.
  - Else: set pend[e-1], go IDLE.
- rx_ack in any state other than IDLE: set err_miss_ack, ACK dropped.
- link_u0 low in NRDY/ERDY/DPH: return to IDLE, drop request, pend unchanged.
- Latency: rx_ack to tx_dph asserted = 2 cycles when data is ready.

Test Plan:
- NUM_EP=4, ep_hasdata=0010, ACK endp 2, nump 1, seq 5, len 512 -> DPH endp 2, seq 5, len 512, eob 1; after done, ep_arm=0010 pulse; ep_sel returns 0.
- ACK endp 3, nump 8, all 1024-byte buffers ready -> exactly 4 DPHs (MAX_BURST), seq 30,31,0,1; eob only on 4th; 4 ep_arm pulses.
- ACK endp 1, no data -> NRDY endp 1 nump 0, pend[0]=1; assert ep_hasdata[0] -> ERDY endp 1 nump 1, pend[0]=0.
- pend=0110, ep_hasdata=0110 simultaneously -> ERDY for endp 2 first, then endp 3.
- ACK endp 0 -> err_bad_endp=1, no TP/DPH. Second ACK while in DPP -> err_miss_ack=1.
- Withhold tx_dpp_done 1024 cycles -> err_dpp_timeout=1, no ep_arm, IDLE. Repeat with link_u0 dropped mid-DPP -> same result.

Source files
------------

// File: rtl/usb3_in_sched.sv
// usb3_in_sched
// -------------
// IN (device-to-host) transaction scheduler for the USB 3.0 protocol layer.
// Serves bulk IN endpoints 1..NUM_EP. For each ACK TP from the host it either
// streams a burst of DPHs out of the endpoint buffer, or answers NRDY and
// remembers the endpoint as pending. A pending endpoint whose buffer fills
// later is announced with ERDY so the host re-issues its ACK.
//
// Ports
//   local_clk, reset_n     clock, synchronous active-low reset
//   link_u0                LTSSM is in U0; dropping it aborts any request
//   rx_ack*                ACK TP from the host (pulse + endpoint/nump/seq)
//   ep_hasdata, ep_len     per-endpoint buffer status, 11-bit length each
//   ep_arm                 one-cycle pulse releasing a transmitted buffer
//   ep_sel                 endpoint driving the buffer read mux, 0 when idle
//   tx_tp*, tx_tp_ack      NRDY/ERDY TP request to the link layer
//   tx_dph*, tx_dpp_ack,   DPH request to the link layer, DPP start and
//   tx_dpp_done            DPP completion handshakes
//   err_*                  sticky error flags, cleared only by reset
//
// All request outputs are registered; a request is raised one cycle after
// its state is entered and drops on the edge where the handshake is seen.

module usb3_in_sched #(
    parameter int NUM_EP      = 4,
    parameter int MAX_BURST   = 4,
    parameter int MAX_PKT     = 1024,
    parameter int DPP_TIMEOUT = 1024
) (
    input  logic                  local_clk,
    input  logic                  reset_n,
    input  logic                  link_u0,
    input  logic                  rx_ack,
    input  logic [3:0]            rx_ack_endp,
    input  logic [4:0]            rx_ack_nump,
    input  logic [4:0]            rx_ack_seq,
    input  logic [NUM_EP-1:0]     ep_hasdata,
    input  logic [NUM_EP*11-1:0]  ep_len,
    output logic [NUM_EP-1:0]     ep_arm,
    output logic [3:0]            ep_sel,
    output logic                  tx_tp,
    output logic [3:0]            tx_tp_subtype,
    output logic [3:0]            tx_tp_endp,
    output logic [4:0]            tx_tp_nump,
    input  logic                  tx_tp_ack,
    output logic                  tx_dph,
    output logic [3:0]            tx_dph_endp,
    output logic [4:0]            tx_dph_seq,
    output logic [15:0]           tx_dph_len,
    output logic                  tx_dph_eob,
    input  logic                  tx_dpp_ack,
    input  logic                  tx_dpp_done,
    output logic                  err_miss_ack,
    output logic                  err_bad_endp,
    output logic                  err_dpp_timeout
);

    // TP subtype codes shared with the rest of the protocol layer
    localparam logic [3:0] TP_NRDY = 4'd2;
    localparam logic [3:0] TP_ERDY = 4'd3;

    localparam logic [3:0]  NUM_EP_L    = 4'(NUM_EP);
    localparam logic [4:0]  MAX_BURST_L = 5'(MAX_BURST);
    localparam logic [11:0] MAX_PKT_L   = 12'(MAX_PKT);
    localparam int          TW          = $clog2(DPP_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DPP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NRDY,
        S_ERDY,
        S_DPH,
        S_DPP,
        S_ARM,
        S_SETTLE
    } state_t;

    state_t state, state_next;

    logic [3:0]        ep_cur, ep_cur_next;
    logic [4:0]        seq, seq_next;
    logic [4:0]        burst, burst_next;
    logic [NUM_EP-1:0] pend, pend_next;
    logic [TW-1:0]     timer, timer_next;
    logic              pkt_eob, pkt_eob_next;

    logic              err_miss_next, err_bad_next, err_tmo_next;

    logic              tp_next;
    logic [3:0]        tp_subtype_next, tp_endp_next;
    logic [4:0]        tp_nump_next;
    logic              dph_next;
    logic [3:0]        dph_endp_next;
    logic [4:0]        dph_seq_next;
    logic [15:0]       dph_len_next;
    logic              dph_eob_next;
    logic [NUM_EP-1:0] arm_next;

    logic [NUM_EP-1:0] cur_mask, ack_mask, ready;
    logic [10:0]       len_cur;
    logic [3:0]        erdy_ep;
    logic              ack_valid, ack_bad, ack_hasdata, cur_hasdata, dph_eob;

    assign ep_sel = ep_cur;
    assign ready  = pend & ep_hasdata;

    // One-hot views of the current and the ACKed endpoint, plus the
    // buffer length of the current endpoint.
    always_comb begin
        cur_mask = '0;
        ack_mask = '0;
        len_cur  = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (ep_cur == 4'(i + 1)) begin
                cur_mask[i] = 1'b1;
                len_cur     = ep_len[11*i +: 11];
            end
            if (rx_ack_endp == 4'(i + 1)) begin
                ack_mask[i] = 1'b1;
            end
        end
    end

    // Lowest-numbered pending endpoint whose buffer has filled; scanning
    // downwards lets the lowest index overwrite the others.
    always_comb begin
        erdy_ep = '0;
        for (int i = NUM_EP - 1; i >= 0; i--) begin
            if (ready[i]) begin
                erdy_ep = 4'(i + 1);
            end
        end
    end

    assign ack_valid   = rx_ack && (rx_ack_nump != 5'd0);
    assign ack_bad     = (rx_ack_endp == 4'd0) || (rx_ack_endp > NUM_EP_L);
    assign ack_hasdata = |(ep_hasdata & ack_mask);
    assign cur_hasdata = |(ep_hasdata & cur_mask);
    assign dph_eob     = (burst == 5'd1) || ({1'b0, len_cur} < MAX_PKT_L);

    // Next-state logic and next values of the registered outputs
    always_comb begin
        state_next    = state;
        ep_cur_next   = ep_cur;
        seq_next      = seq;
        burst_next    = burst;
        pend_next     = pend;
        timer_next    = timer;
        pkt_eob_next  = pkt_eob;
        err_miss_next = err_miss_ack;
        err_bad_next  = err_bad_endp;
        err_tmo_next  = err_dpp_timeout;

        // The scheduler handles one ACK at a time; anything arriving while
        // busy is lost and the host will time out and retry.
        if (rx_ack && (state != S_IDLE)) begin
            err_miss_next = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (ack_valid) begin
                    if (ack_bad) begin
                        err_bad_next = 1'b1;
                    end else begin
                        ep_cur_next = rx_ack_endp;
                        seq_next    = rx_ack_seq;
                        burst_next  = (rx_ack_nump > MAX_BURST_L) ? MAX_BURST_L : rx_ack_nump;
                        state_next  = ack_hasdata ? S_DPH : S_NRDY;
                    end
                end else if (!rx_ack && (|ready)) begin
                    ep_cur_next = erdy_ep;
                    state_next  = S_ERDY;
                end
            end

            S_NRDY: begin
                if (!link_u0) begin
                    ep_cur_next = '0;
                    state_next  = S_IDLE;
                end else if (tx_tp && tx_tp_ack) begin
                    pend_next   = pend | cur_mask;
                    ep_cur_next = '0;
                    state_next  = S_IDLE;
                end
            end

            S_ERDY: begin
                if (!link_u0) begin
                    ep_cur_next = '0;
                    state_next  = S_IDLE;
                end else if (tx_tp && tx_tp_ack) begin
                    pend_next   = pend & ~cur_mask;
                    ep_cur_next = '0;
                    state_next  = S_IDLE;
                end
            end

            S_DPH: begin
                if (!link_u0) begin
                    ep_cur_next = '0;
                    state_next  = S_IDLE;
                end else if (tx_dph && tx_dpp_ack) begin
                    timer_next   = '0;
                    pkt_eob_next = tx_dph_eob;
                    state_next   = S_DPP;
                end
            end

            // A finished DPP wins over a coincident abort condition. An
            // aborted packet keeps its buffer so the host can retry.
            S_DPP: begin
                if (tx_dpp_done) begin
                    state_next = S_ARM;
                end else if (!link_u0 || (timer == TMO_LAST)) begin
                    err_tmo_next = 1'b1;
                    ep_cur_next  = '0;
                    state_next   = S_IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end

            S_ARM: begin
                seq_next   = seq + 5'd1;
                burst_next = burst - 5'd1;
                if (pkt_eob || (burst == 5'd1)) begin
                    ep_cur_next = '0;
                    state_next  = S_IDLE;
                end else begin
                    state_next = S_SETTLE;
                end
            end

            // Buffer status is only valid again one cycle after the arm
            // pulse, so the refill decision is made here.
            S_SETTLE: begin
                if (cur_hasdata) begin
                    state_next = S_DPH;
                end else begin
                    pend_next   = pend | cur_mask;
                    ep_cur_next = '0;
                    state_next  = S_IDLE;
                end
            end

            default: begin
                ep_cur_next = '0;
                state_next  = S_IDLE;
            end
        endcase

        // Requests rise one cycle into their state and fall on the edge
        // that leaves it, so the handshake edge also clears the request.
        tp_next         = ((state == S_NRDY) || (state == S_ERDY)) && (state_next == state);
        tp_subtype_next = '0;
        tp_endp_next    = '0;
        tp_nump_next    = '0;
        if (tp_next) begin
            tp_subtype_next = (state == S_ERDY) ? TP_ERDY : TP_NRDY;
            tp_endp_next    = ep_cur;
            tp_nump_next    = (state == S_ERDY) ? 5'd1 : 5'd0;
        end

        dph_next      = (state == S_DPH) && (state_next == S_DPH);
        dph_endp_next = '0;
        dph_seq_next  = '0;
        dph_len_next  = '0;
        dph_eob_next  = 1'b0;
        if (dph_next) begin
            dph_endp_next = ep_cur;
            dph_seq_next  = seq;
            dph_len_next  = {5'd0, len_cur};
            dph_eob_next  = dph_eob;
        end

        arm_next = (state_next == S_ARM) ? cur_mask : '0;
    end

    // State and output registers; reset overrides everything, including an
    // arm pulse that would otherwise have been issued on the same edge.
    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            ep_cur          <= '0;
            seq             <= '0;
            burst           <= '0;
            pend            <= '0;
            timer           <= '0;
            pkt_eob         <= 1'b0;
            err_miss_ack    <= 1'b0;
            err_bad_endp    <= 1'b0;
            err_dpp_timeout <= 1'b0;
            tx_tp           <= 1'b0;
            tx_tp_subtype   <= '0;
            tx_tp_endp      <= '0;
            tx_tp_nump      <= '0;
            tx_dph          <= 1'b0;
            tx_dph_endp     <= '0;
            tx_dph_seq      <= '0;
            tx_dph_len      <= '0;
            tx_dph_eob      <= 1'b0;
            ep_arm          <= '0;
        end else begin
            state           <= state_next;
            ep_cur          <= ep_cur_next;
            seq             <= seq_next;
            burst           <= burst_next;
            pend            <= pend_next;
            timer           <= timer_next;
            pkt_eob         <= pkt_eob_next;
            err_miss_ack    <= err_miss_next;
            err_bad_endp    <= err_bad_next;
            err_dpp_timeout <= err_tmo_next;
            tx_tp           <= tp_next;
            tx_tp_subtype   <= tp_subtype_next;
            tx_tp_endp      <= tp_endp_next;
            tx_tp_nump      <= tp_nump_next;
            tx_dph          <= dph_next;
            tx_dph_endp     <= dph_endp_next;
            tx_dph_seq      <= dph_seq_next;
            tx_dph_len      <= dph_len_next;
            tx_dph_eob      <= dph_eob_next;
            ep_arm          <= arm_next;
        end
    end

endmodule

// File: tb/tb_usb3_in_sched.sv
// tb_usb3_in_sched
// ----------------
// Directed bench for usb3_in_sched with NUM_EP=4, MAX_BURST=4, MAX_PKT=1024,
// DPP_TIMEOUT=1024. Each scenario task drives its own stimulus and compares
// outputs against hand-computed values. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.

module tb_usb3_in_sched;

    logic        local_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        link_u0 = 1'b1;
    logic        rx_ack = 1'b0;
    logic [3:0]  rx_ack_endp = '0;
    logic [4:0]  rx_ack_nump = '0;
    logic [4:0]  rx_ack_seq = '0;
    logic [3:0]  ep_hasdata = '0;
    logic [43:0] ep_len = '0;
    logic [3:0]  ep_arm;
    logic [3:0]  ep_sel;
    logic        tx_tp;
    logic [3:0]  tx_tp_subtype;
    logic [3:0]  tx_tp_endp;
    logic [4:0]  tx_tp_nump;
    logic        tx_tp_ack = 1'b0;
    logic        tx_dph;
    logic [3:0]  tx_dph_endp;
    logic [4:0]  tx_dph_seq;
    logic [15:0] tx_dph_len;
    logic        tx_dph_eob;
    logic        tx_dpp_ack = 1'b0;
    logic        tx_dpp_done = 1'b0;
    logic        err_miss_ack;
    logic        err_bad_endp;
    logic        err_dpp_timeout;

    int total = 0;
    int bad = 0;
    int arm_count = 0;

    usb3_in_sched #(
        .NUM_EP(4),
        .MAX_BURST(4),
        .MAX_PKT(1024),
        .DPP_TIMEOUT(1024)
    ) dut (
        .local_clk(local_clk),
        .reset_n(reset_n),
        .link_u0(link_u0),
        .rx_ack(rx_ack),
        .rx_ack_endp(rx_ack_endp),
        .rx_ack_nump(rx_ack_nump),
        .rx_ack_seq(rx_ack_seq),
        .ep_hasdata(ep_hasdata),
        .ep_len(ep_len),
        .ep_arm(ep_arm),
        .ep_sel(ep_sel),
        .tx_tp(tx_tp),
        .tx_tp_subtype(tx_tp_subtype),
        .tx_tp_endp(tx_tp_endp),
        .tx_tp_nump(tx_tp_nump),
        .tx_tp_ack(tx_tp_ack),
        .tx_dph(tx_dph),
        .tx_dph_endp(tx_dph_endp),
        .tx_dph_seq(tx_dph_seq),
        .tx_dph_len(tx_dph_len),
        .tx_dph_eob(tx_dph_eob),
        .tx_dpp_ack(tx_dpp_ack),
        .tx_dpp_done(tx_dpp_done),
        .err_miss_ack(err_miss_ack),
        .err_bad_endp(err_bad_endp),
        .err_dpp_timeout(err_dpp_timeout)
    );

    always #5 local_clk = ~local_clk;

    // Running count of arm pulses, sampled on the falling edge
    always @(negedge local_clk) begin
        if (|ep_arm) arm_count <= arm_count + 1;
    end

    // ---------------- stimulus helpers (no comparisons) ----------------

    task automatic do_reset();
        rx_ack = 1'b0; tx_tp_ack = 1'b0; tx_dpp_ack = 1'b0; tx_dpp_done = 1'b0;
        link_u0 = 1'b1; ep_hasdata = '0;
        reset_n = 1'b0;
        @(negedge local_clk);
        @(negedge local_clk);
        reset_n = 1'b1;
    endtask

    task automatic do_ack(input logic [3:0] endp, input logic [4:0] nump, input logic [4:0] seq);
        rx_ack_endp = endp; rx_ack_nump = nump; rx_ack_seq = seq;
        rx_ack = 1'b1;
        @(negedge local_clk);
        rx_ack = 1'b0;
    endtask

    task automatic wait_dph(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            if (tx_dph === 1'b1) ok = 1'b1;
            else begin @(negedge local_clk); n++; end
        end
    endtask

    task automatic wait_tp(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            if (tx_tp === 1'b1) ok = 1'b1;
            else begin @(negedge local_clk); n++; end
        end
    endtask

    task automatic pulse_tp_ack();
        tx_tp_ack = 1'b1;
        @(negedge local_clk);
        tx_tp_ack = 1'b0;
    endtask

    task automatic pulse_dpp_ack();
        tx_dpp_ack = 1'b1;
        @(negedge local_clk);
        tx_dpp_ack = 1'b0;
    endtask

    task automatic pulse_done();
        tx_dpp_done = 1'b1;
        @(negedge local_clk);
        tx_dpp_done = 1'b0;
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge local_clk);
        total++; if (ep_arm !== 4'b0 || ep_sel !== 4'd0) begin bad++;
            $display("[TB] FAIL reset_ep: arm=%b sel=%0d want 0/0", ep_arm, ep_sel); end
        total++; if (tx_tp !== 1'b0 || tx_dph !== 1'b0) begin bad++;
            $display("[TB] FAIL reset_req: tp=%b dph=%b want 0/0", tx_tp, tx_dph); end
        total++; if ({err_miss_ack, err_bad_endp, err_dpp_timeout} !== 3'b000) begin bad++;
            $display("[TB] FAIL reset_err: got %b want 000", {err_miss_ack, err_bad_endp, err_dpp_timeout}); end
        reset_n = 1'b1;
        @(negedge local_clk);
    endtask

    task automatic test_single();
        ep_hasdata = 4'b0010;
        ep_len = {11'd0, 11'd0, 11'd512, 11'd0};
        do_ack(4'd2, 5'd1, 5'd5);
        total++; if (ep_sel !== 4'd2 || tx_dph !== 1'b0) begin bad++;
            $display("[TB] FAIL single_latency1: sel=%0d dph=%b want 2/0", ep_sel, tx_dph); end
        @(negedge local_clk);
        total++; if (tx_dph !== 1'b1) begin bad++;
            $display("[TB] FAIL single_latency2: dph=%b want 1", tx_dph); end
        total++; if (tx_dph_endp !== 4'd2 || tx_dph_seq !== 5'd5 || tx_dph_len !== 16'd512 || tx_dph_eob !== 1'b1) begin bad++;
            $display("[TB] FAIL single_fields: endp=%0d seq=%0d len=%0d eob=%b want 2/5/512/1",
                     tx_dph_endp, tx_dph_seq, tx_dph_len, tx_dph_eob); end
        pulse_dpp_ack();
        total++; if (tx_dph !== 1'b0) begin bad++;
            $display("[TB] FAIL single_dph_drop: dph=%b want 0", tx_dph); end
        pulse_done();
        total++; if (ep_arm !== 4'b0010 || ep_sel !== 4'd2) begin bad++;
            $display("[TB] FAIL single_arm: arm=%b sel=%0d want 0010/2", ep_arm, ep_sel); end
        ep_hasdata = 4'b0000;
        @(negedge local_clk);
        total++; if (ep_arm !== 4'b0000 || ep_sel !== 4'd0) begin bad++;
            $display("[TB] FAIL single_idle: arm=%b sel=%0d want 0000/0", ep_arm, ep_sel); end
    endtask

    task automatic test_burst();
        int seq_tab[4] = '{30, 31, 0, 1};
        int arms0;
        int dph_seen = 0;
        bit ok;
        ep_hasdata = 4'b1111;
        ep_len = {11'd1024, 11'd1024, 11'd1024, 11'd1024};
        arms0 = arm_count;
        do_ack(4'd3, 5'd8, 5'd30);
        for (int k = 0; k < 4; k++) begin
            wait_dph(ok);
            total++; if (!ok) begin bad++;
                $display("[TB] FAIL burst_dph_wait%0d: no DPH within 50 cycles", k); end
            total++; if (tx_dph_seq !== 5'(seq_tab[k]) || tx_dph_eob !== (k == 3) || tx_dph_endp !== 4'd3 || tx_dph_len !== 16'd1024) begin bad++;
                $display("[TB] FAIL burst_pkt%0d: seq=%0d eob=%b endp=%0d len=%0d want %0d/%b/3/1024",
                         k, tx_dph_seq, tx_dph_eob, tx_dph_endp, tx_dph_len, seq_tab[k], (k == 3)); end
            pulse_dpp_ack();
            pulse_done();
            total++; if (ep_arm !== 4'b0100) begin bad++;
                $display("[TB] FAIL burst_arm%0d: arm=%b want 0100", k, ep_arm); end
            @(negedge local_clk);
        end
        total++; if (ep_sel !== 4'd0) begin bad++;
            $display("[TB] FAIL burst_sel_idle: sel=%0d want 0", ep_sel); end
        for (int i = 0; i < 10; i++) begin
            @(negedge local_clk);
            if (tx_dph) dph_seen++;
        end
        total++; if (dph_seen != 0 || (arm_count - arms0) != 4) begin bad++;
            $display("[TB] FAIL burst_count: extra_dph=%0d arms=%0d want 0/4", dph_seen, arm_count - arms0); end
        ep_hasdata = 4'b0000;
    endtask

    task automatic test_short();
        int seen = 0;
        bit ok;
        ep_hasdata = 4'b1000;
        ep_len = {11'd1023, 11'd0, 11'd0, 11'd0};
        do_ack(4'd4, 5'd3, 5'd7);
        wait_dph(ok);
        total++; if (!ok || tx_dph_eob !== 1'b1 || tx_dph_len !== 16'd1023 || tx_dph_seq !== 5'd7 || tx_dph_endp !== 4'd4) begin bad++;
            $display("[TB] FAIL short_pkt: ok=%b eob=%b len=%0d seq=%0d endp=%0d want 1/1/1023/7/4",
                     ok, tx_dph_eob, tx_dph_len, tx_dph_seq, tx_dph_endp); end
        pulse_dpp_ack();
        pulse_done();
        total++; if (ep_arm !== 4'b1000) begin bad++;
            $display("[TB] FAIL short_arm: arm=%b want 1000", ep_arm); end
        for (int i = 0; i < 10; i++) begin
            @(negedge local_clk);
            if (tx_dph || tx_tp) seen++;
        end
        total++; if (seen != 0 || ep_sel !== 4'd0) begin bad++;
            $display("[TB] FAIL short_end: extra_req=%0d sel=%0d want 0/0", seen, ep_sel); end
        ep_hasdata = 4'b0000;
    endtask

    task automatic test_nrdy_erdy();
        int seen = 0;
        bit ok;
        ep_hasdata = 4'b0000;
        do_ack(4'd1, 5'd2, 5'd0);
        total++; if (ep_sel !== 4'd1 || tx_tp !== 1'b0) begin bad++;
            $display("[TB] FAIL nrdy_sel: sel=%0d tp=%b want 1/0", ep_sel, tx_tp); end
        wait_tp(ok);
        total++; if (!ok || tx_tp_subtype !== 4'd2 || tx_tp_endp !== 4'd1 || tx_tp_nump !== 5'd0 || tx_dph !== 1'b0) begin bad++;
            $display("[TB] FAIL nrdy_tp: ok=%b sub=%0d endp=%0d nump=%0d dph=%b want 1/2/1/0/0",
                     ok, tx_tp_subtype, tx_tp_endp, tx_tp_nump, tx_dph); end
        pulse_tp_ack();
        total++; if (tx_tp !== 1'b0 || ep_sel !== 4'd0) begin bad++;
            $display("[TB] FAIL nrdy_drop: tp=%b sel=%0d want 0/0", tx_tp, ep_sel); end
        for (int i = 0; i < 5; i++) begin
            @(negedge local_clk);
            if (tx_tp) seen++;
        end
        total++; if (seen != 0) begin bad++;
            $display("[TB] FAIL nrdy_quiet: tp_cycles=%0d want 0", seen); end
        ep_hasdata = 4'b0001;
        wait_tp(ok);
        total++; if (!ok || tx_tp_subtype !== 4'd3 || tx_tp_endp !== 4'd1 || tx_tp_nump !== 5'd1 || ep_sel !== 4'd1) begin bad++;
            $display("[TB] FAIL erdy_tp: ok=%b sub=%0d endp=%0d nump=%0d sel=%0d want 1/3/1/1/1",
                     ok, tx_tp_subtype, tx_tp_endp, tx_tp_nump, ep_sel); end
        pulse_tp_ack();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge local_clk);
            if (tx_tp) seen++;
        end
        total++; if (seen != 0) begin bad++;
            $display("[TB] FAIL erdy_pend_clear: tp_cycles=%0d want 0", seen); end
        ep_hasdata = 4'b0000;
    endtask

    task automatic test_erdy_priority();
        bit ok;
        ep_hasdata = 4'b0000;
        do_ack(4'd2, 5'd1, 5'd0);
        wait_tp(ok);
        pulse_tp_ack();
        do_ack(4'd3, 5'd1, 5'd0);
        wait_tp(ok);
        pulse_tp_ack();
        ep_hasdata = 4'b0110;
        wait_tp(ok);
        total++; if (!ok || tx_tp_subtype !== 4'd3 || tx_tp_endp !== 4'd2) begin bad++;
            $display("[TB] FAIL prio_first: ok=%b sub=%0d endp=%0d want 1/3/2", ok, tx_tp_subtype, tx_tp_endp); end
        pulse_tp_ack();
        wait_tp(ok);
        total++; if (!ok || tx_tp_subtype !== 4'd3 || tx_tp_endp !== 4'd3) begin bad++;
            $display("[TB] FAIL prio_second: ok=%b sub=%0d endp=%0d want 1/3/3", ok, tx_tp_subtype, tx_tp_endp); end
        pulse_tp_ack();
        ep_hasdata = 4'b0000;
    endtask

    task automatic test_bad_endp();
        int seen = 0;
        do_reset();
        do_ack(4'd0, 5'd1, 5'd0);
        total++; if (err_bad_endp !== 1'b1 || ep_sel !== 4'd0) begin bad++;
            $display("[TB] FAIL bad_endp0: err=%b sel=%0d want 1/0", err_bad_endp, ep_sel); end
        for (int i = 0; i < 6; i++) begin
            @(negedge local_clk);
            if (tx_tp || tx_dph) seen++;
        end
        total++; if (seen != 0) begin bad++;
            $display("[TB] FAIL bad_endp0_quiet: req_cycles=%0d want 0", seen); end
        do_reset();
        total++; if (err_bad_endp !== 1'b0) begin bad++;
            $display("[TB] FAIL bad_endp_reset: err=%b want 0", err_bad_endp); end
        do_ack(4'd5, 5'd1, 5'd0);
        total++; if (err_bad_endp !== 1'b1) begin bad++;
            $display("[TB] FAIL bad_endp5: err=%b want 1", err_bad_endp); end
        do_reset();
        ep_hasdata = 4'b0010;
        do_ack(4'd2, 5'd0, 5'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge local_clk);
            if (tx_tp || tx_dph || ep_sel != 4'd0) seen++;
        end
        total++; if (seen != 0 || err_bad_endp !== 1'b0) begin bad++;
            $display("[TB] FAIL nump0_ignored: busy_cycles=%0d err=%b want 0/0", seen, err_bad_endp); end
        ep_hasdata = 4'b0000;
    endtask

    task automatic test_miss_ack();
        bit ok;
        do_reset();
        ep_hasdata = 4'b0010;
        ep_len = {11'd0, 11'd0, 11'd512, 11'd0};
        do_ack(4'd2, 5'd1, 5'd3);
        wait_dph(ok);
        pulse_dpp_ack();
        total++; if (err_miss_ack !== 1'b0) begin bad++;
            $display("[TB] FAIL miss_before: err=%b want 0", err_miss_ack); end
        do_ack(4'd1, 5'd1, 5'd0);
        total++; if (err_miss_ack !== 1'b1 || ep_sel !== 4'd2) begin bad++;
            $display("[TB] FAIL miss_set: err=%b sel=%0d want 1/2", err_miss_ack, ep_sel); end
        pulse_done();
        total++; if (ep_arm !== 4'b0010) begin bad++;
            $display("[TB] FAIL miss_arm: arm=%b want 0010", ep_arm); end
        ep_hasdata = 4'b0000;
        @(negedge local_clk);
    endtask

    task automatic test_timeout();
        int arms0;
        bit ok;
        do_reset();
        ep_hasdata = 4'b0010;
        ep_len = {11'd0, 11'd0, 11'd512, 11'd0};
        do_ack(4'd2, 5'd1, 5'd0);
        wait_dph(ok);
        arms0 = arm_count;
        pulse_dpp_ack();
        repeat (1023) @(negedge local_clk);
        total++; if (err_dpp_timeout !== 1'b0 || ep_sel !== 4'd2) begin bad++;
            $display("[TB] FAIL tmo_early: err=%b sel=%0d want 0/2", err_dpp_timeout, ep_sel); end
        @(negedge local_clk);
        total++; if (err_dpp_timeout !== 1'b1 || ep_sel !== 4'd0 || tx_dph !== 1'b0) begin bad++;
            $display("[TB] FAIL tmo_fire: err=%b sel=%0d dph=%b want 1/0/0", err_dpp_timeout, ep_sel, tx_dph); end
        repeat (3) @(negedge local_clk);
        total++; if (arm_count != arms0) begin bad++;
            $display("[TB] FAIL tmo_no_arm: arms=%0d want 0", arm_count - arms0); end

        do_reset();
        ep_hasdata = 4'b0010;
        do_ack(4'd2, 5'd1, 5'd0);
        wait_dph(ok);
        arms0 = arm_count;
        pulse_dpp_ack();
        repeat (5) @(negedge local_clk);
        total++; if (err_dpp_timeout !== 1'b0) begin bad++;
            $display("[TB] FAIL link_before: err=%b want 0", err_dpp_timeout); end
        link_u0 = 1'b0;
        @(negedge local_clk);
        total++; if (err_dpp_timeout !== 1'b1 || ep_sel !== 4'd0) begin bad++;
            $display("[TB] FAIL link_drop: err=%b sel=%0d want 1/0", err_dpp_timeout, ep_sel); end
        link_u0 = 1'b1;
        repeat (3) @(negedge local_clk);
        total++; if (arm_count != arms0 || tx_dph !== 1'b0) begin bad++;
            $display("[TB] FAIL link_no_arm: arms=%0d dph=%b want 0/0", arm_count - arms0, tx_dph); end
        ep_hasdata = 4'b0000;
    endtask

    task automatic test_reset_midop();
        bit ok;
        do_reset();
        ep_hasdata = 4'b0010;
        do_ack(4'd2, 5'd1, 5'd0);
        wait_dph(ok);
        pulse_dpp_ack();
        tx_dpp_done = 1'b1;
        reset_n = 1'b0;
        @(negedge local_clk);
        tx_dpp_done = 1'b0;
        total++; if (ep_arm !== 4'b0000 || ep_sel !== 4'd0 || tx_dph !== 1'b0) begin bad++;
            $display("[TB] FAIL reset_midop: arm=%b sel=%0d dph=%b want 0000/0/0", ep_arm, ep_sel, tx_dph); end
        reset_n = 1'b1;
        ep_hasdata = 4'b0000;
        @(negedge local_clk);
    endtask

    initial begin
        $display("[TB] starting usb3_in_sched bench");
        test_reset();
        test_single();
        test_burst();
        test_short();
        test_nrdy_erdy();
        test_erdy_priority();
        test_bad_endp();
        test_miss_ack();
        test_timeout();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
